// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
package rr_arb8_ctrl_pkg;

  localparam int unsigned N_REQ        = 8;
  localparam int unsigned ID_W         = 3;
  localparam int unsigned MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set request scanning upward from last_id+1.
module rr_pick8
  import rr_arb8_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_valid
);

  logic [ID_W-1:0] w_idx;

  // Walk the eight positions after last_id (wrapping) and keep the first hit.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    w_idx      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'(last_id + ID_W'(k));
      if (!pick_valid && req[w_idx]) begin
        pick_valid = 1'b1;
        pick_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// 8-requester round-robin arbiter with bounded hold time and timeout preemption.
module rr_arb8_ctrl
  import rr_arb8_ctrl_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  state_e             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic               r_gnt_valid;
  logic               r_preempt;
  logic [HOLD_W-1:0]  r_hold;
  logic [ID_W-1:0]    r_last_id;
  logic               r_armed;

  state_e             w_state_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [ID_W-1:0]    w_gnt_id_nxt;
  logic               w_gnt_valid_nxt;
  logic               w_preempt_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [ID_W-1:0]    w_last_id_nxt;

  logic [ID_W-1:0]    w_pick_id;
  logic               w_pick_valid;

  rr_pick8 u_pick (
    .req        (req),
    .last_id    (r_last_id),
    .pick_id    (w_pick_id),
    .pick_valid (w_pick_valid)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_preempt_nxt   = 1'b0;
    w_hold_nxt      = r_hold;
    w_last_id_nxt   = r_last_id;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        w_hold_nxt      = '0;
        // r_armed holds off grants until the second edge after reset release.
        if (r_armed && en && w_pick_valid) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_nxt       = N_REQ'(1) << w_pick_id;
          w_gnt_id_nxt    = w_pick_id;
          w_gnt_valid_nxt = 1'b1;
          w_hold_nxt      = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (!req[r_gnt_id] || (r_hold == HOLD_W'(MAX_HOLD))) begin
          w_state_nxt     = ST_IDLE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_hold_nxt      = '0;
          w_last_id_nxt   = r_gnt_id;
          w_preempt_nxt   = req[r_gnt_id];
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        w_hold_nxt      = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
      r_hold      <= '0;
      r_last_id   <= ID_W'(N_REQ - 1);
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_preempt   <= w_preempt_nxt;
      r_hold      <= w_hold_nxt;
      r_last_id   <= w_last_id_nxt;
      r_armed     <= 1'b1;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed bench for rr_arb8_ctrl with MAX_HOLD=4.
module tb_rr_arb8_ctrl;
  import rr_arb8_ctrl_pkg::*;

  localparam int unsigned TB_HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  rr_arb8_ctrl #(.MAX_HOLD(TB_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                     input logic ev, input logic ep);
    checks++;
    assert (gnt === eg) else begin
      errors++; $error("FAIL %s gnt got=%h exp=%h", tag, gnt, eg);
    end
    checks++;
    assert (gnt_id === ei) else begin
      errors++; $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, ei);
    end
    checks++;
    assert (gnt_valid === ev) else begin
      errors++; $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, ev);
    end
    checks++;
    assert (preempt === ep) else begin
      errors++; $error("FAIL %s preempt got=%b exp=%b", tag, preempt, ep);
    end
    checks++;
    assert ($onehot0(gnt) === 1'b1) else begin
      errors++; $error("FAIL %s onehot gnt got=%h exp=at most one bit", tag, gnt);
    end
  endtask

  logic [2:0] eid;
  logic [7:0] ebit;

  initial begin
    // Reset values; request already pending at release.
    req = 8'h01; en = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("first_edge_no_grant", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk("grant0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk("release0", 8'h00, 3'd0, 1'b0, 1'b0);

    // Full rotation, each owner holds 3 cycles then drops; last_id=0 so start at 1.
    for (int i = 0; i < 8; i++) begin
      eid  = 3'(i + 1);
      ebit = 8'(1) << eid;
      req = 8'hFF;
      tick(); chk("rr_grant", ebit, eid, 1'b1, 1'b0);
      tick(); tick();
      req = 8'hFF & ~ebit;
      tick(); chk("rr_gap", 8'h00, eid, 1'b0, 1'b0);
    end
    req = 8'h00;
    tick(); chk("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Timeout preemption alternates between 2 and 5.
    req = 8'h24;
    tick(); chk("pre_g2", 8'h04, 3'd2, 1'b1, 1'b0);
    repeat (3) begin tick(); chk("pre_hold2", 8'h04, 3'd2, 1'b1, 1'b0); end
    tick(); chk("pre_pulse2", 8'h00, 3'd2, 1'b0, 1'b1);
    tick(); chk("pre_g5", 8'h20, 3'd5, 1'b1, 1'b0);
    repeat (3) begin tick(); chk("pre_hold5", 8'h20, 3'd5, 1'b1, 1'b0); end
    tick(); chk("pre_pulse5", 8'h00, 3'd5, 1'b0, 1'b1);
    tick(); chk("pre_g2_again", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk("pre_release", 8'h00, 3'd2, 1'b0, 1'b0);

    // Sole requester is preempted then re-granted after one idle cycle.
    req = 8'h08;
    tick(); chk("solo_g3", 8'h08, 3'd3, 1'b1, 1'b0);
    repeat (3) begin tick(); chk("solo_hold", 8'h08, 3'd3, 1'b1, 1'b0); end
    tick(); chk("solo_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    tick(); chk("solo_regrant", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk("solo_release", 8'h00, 3'd3, 1'b0, 1'b0);

    // Enable gating, grant survives en low, other bits ignored while granted.
    en = 1'b0; req = 8'h10;
    tick(); chk("en_off_a", 8'h00, 3'd3, 1'b0, 1'b0);
    tick(); chk("en_off_b", 8'h00, 3'd3, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk("en_on_g4", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk("en_drop_hold", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h13;
    tick(); chk("other_bits", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h03;
    tick(); chk("en_release", 8'h00, 3'd4, 1'b0, 1'b0);
    tick(); chk("en_off_idle", 8'h00, 3'd4, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then scan restarts at requester 0.
    en = 1'b1; req = 8'h40;
    tick(); chk("g6", 8'h40, 3'd6, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'hC0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("post_reset_wait", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk("post_reset_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk("post_reset_rel", 8'h00, 3'd6, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb8_ctrl.md
RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL be the maximum number of consecutive cycles one grant may be held (legal 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  arbitration enable; new grants SHALL be issued only while high.
REQ-005 req  input  8  per-requester request, bit k = requester k; held high for as long as the resource is wanted.
REQ-006 gnt  output  8  one-hot grant, registered.
REQ-007 gnt_id  output  3  binary index of the granted requester, registered.
REQ-008 gnt_valid  output  1  high exactly when gnt is non-zero, registered.
REQ-009 preempt  output  1  one-cycle pulse, registered, marking a grant removed by hold timeout.

Function
REQ-010 FSM SHALL have two states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-011 In IDLE with en=1 and req!=0, the winner SHALL be the first set req bit scanning upward from (last_id+1) mod 8 with wrap-around.
REQ-012 In that case, next cycle: state=GRANT, gnt=one-hot(winner), gnt_id=winner, gnt_valid=1 (latency 1 cycle req->gnt).
REQ-013 In IDLE with en=0 or req=0, all outputs SHALL remain at their idle values.
REQ-014 In GRANT, if req[gnt_id]=0, next cycle SHALL return to IDLE with gnt=0, gnt_valid=0; last_id<=gnt_id.
REQ-015 In GRANT, a hold counter SHALL count granted cycles starting at 1 on the first grant cycle.
REQ-016 When the counter equals MAX_HOLD and req[gnt_id] is still 1, next cycle SHALL be IDLE with preempt=1 for that one cycle; last_id<=gnt_id.
REQ-017 Every release (voluntary or preempt) SHALL be followed by at least one IDLE cycle with gnt=0 before any new grant.
REQ-018 en falling during GRANT SHALL NOT remove the current grant; only REQ-014/REQ-016 end it.
REQ-019 Changes on req bits other than gnt_id during GRANT SHALL have no effect until the next IDLE evaluation.
REQ-020 A preempted requester SHALL be re-granted immediately only if no other req bit is set at the IDLE evaluation.
REQ-021 gnt_id SHALL hold its last value while in IDLE; gnt and gnt_valid SHALL be 0 in IDLE.
REQ-022 gnt SHALL never have more than one bit set in any cycle.
REQ-023 Hold counter SHALL be wide enough for MAX_HOLD and SHALL clear on every entry to IDLE.

Reset
REQ-024 rst_n low SHALL asynchronously force: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, hold counter=0, last_id=7 (first scan starts at requester 0).
REQ-025 Reset asserted mid-grant SHALL drop the grant immediately, with no preempt pulse.
REQ-026 After rst_n deasserts, the first grant SHALL appear no earlier than the second rising edge.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, N_REQ=8, ID_W=3, and the default MAX_HOLD.
REQ-028 Sub-module rr_pick8 SHALL be a purely combinational rotating priority encoder: inputs req[7:0] and last_id[2:0]; outputs pick_id[2:0] and pick_valid.
REQ-029 FSM, hold counter and output registers SHALL reside in rr_arb8_ctrl.

Verification
REQ-030 Reset release, en=1, req=8'b0000_0001 -> gnt=8'h01, gnt_id=0 one cycle later; drop req[0] -> gnt=0 the next cycle.
REQ-031 req=8'hFF held, each requester drops its req after 3 cycles then re-raises -> grant order 0,1,2,...,7,0 with a 1-cycle gap between grants.
REQ-032 MAX_HOLD=4, req=8'h24 held constant -> id 2 granted 4 cycles, preempt=1 for one cycle, then id 5 granted; preempt later ends id 5's grant and id 2 is granted.
REQ-033 MAX_HOLD=4, only req[3] held -> grant for 4 cycles, preempt pulse, 1 IDLE cycle, then id 3 is re-granted.
REQ-034 en=0 with req=8'h10 -> no grant; en=1 -> gnt=8'h10 next cycle; en=0 during the grant -> the grant persists until req[4] drops.
REQ-035 rst_n pulsed low mid-grant of id 6 -> gnt=0 immediately, preempt=0; after release, req=8'hC0 -> id 6 is granted first (scan starts at requester 0).
